// File: rtl/pe_result_drain_pkg.sv
// Shared definitions for the PE row result drain: FSM states and index-width helper.
package pe_result_drain_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_e;

  // Index width for a table of n entries; never returns less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_result_drain_slot_buf.sv
// Snapshot storage: SLOTS rows of N words, one full-row write, one word-wide read.
module pe_result_drain_slot_buf
  import pe_result_drain_pkg::*;
#(
  parameter int W     = 16,
  parameter int N     = 4,
  parameter int SLOTS = 2
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [clog2_min1(SLOTS)-1:0]   waddr,
  input  logic [N*W-1:0]                 wdata,
  input  logic [clog2_min1(SLOTS)-1:0]   raddr,
  input  logic [clog2_min1(N)-1:0]       ridx,
  output logic [W-1:0]                   rdata
);

  logic [W-1:0] mem [SLOTS][N];

  // Row write: every word of the snapshot lands in its slot on the capture edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < N; k++) begin
        mem[waddr][k] <= wdata[k*W +: W];
      end
    end
  end

  // Word read is combinational so a row written on edge t is readable right after it.
  always_comb begin
    rdata = mem[raddr][ridx];
  end

endmodule

// File: rtl/pe_result_drain.sv
// Captures a PE row's accumulator outputs on done and streams them out one word per beat.
//
// state  | meaning
// IDLE   | no snapshot buffered, o_valid low
// STREAM | presenting word idx of the oldest snapshot, o_valid high
module pe_result_drain
  import pe_result_drain_pkg::*;
#(
  parameter int W     = 16,
  parameter int N     = 4,
  parameter int SLOTS = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_done,
  input  logic [N*W-1:0]            i_C,
  output logic                      o_cap_rdy,
  output logic [W-1:0]              o_data,
  output logic [clog2_min1(N)-1:0]  o_idx,
  output logic                      o_last,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_overflow,
  input  logic                      i_clr_ovf
);

  localparam int IW = clog2_min1(N);
  localparam int PW = clog2_min1(SLOTS);
  localparam int OW = $clog2(SLOTS + 1);

  drain_state_e  state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ, occ_nx;
  logic          ovf;
  logic          xfer, last_beat, free_slot, cap, ovf_set;
  logic [W-1:0]  rd_word;

  pe_result_drain_slot_buf #(
    .W     (W),
    .N     (N),
    .SLOTS (SLOTS)
  ) u_slot_buf (
    .clk   (i_clk),
    .we    (cap),
    .waddr (wr_ptr),
    .wdata (i_C),
    .raddr (rd_ptr),
    .ridx  (idx),
    .rdata (rd_word)
  );

  // State, beat index, pointers, occupancy and sticky overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      occ   <= occ_nx;
      if (cap) begin
        wr_ptr <= (wr_ptr == PW'(SLOTS - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (free_slot) begin
        rd_ptr <= (rd_ptr == PW'(SLOTS - 1)) ? '0 : rd_ptr + PW'(1);
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  // Capture acceptance, occupancy update and stream sequencing.
  // A final-beat transfer frees its slot in the same cycle, so a done arriving
  // then is accepted even though o_cap_rdy (from the registered count) shows 0.
  always_comb begin
    last_beat = (state == STREAM) && (idx == IW'(N - 1));
    xfer      = (state == STREAM) && i_ready;
    free_slot = xfer && last_beat;
    cap       = i_done && ((occ != OW'(SLOTS)) || free_slot);
    ovf_set   = i_done && !cap;
    occ_nx    = occ + OW'(cap) - OW'(free_slot);
    state_nx  = state;
    idx_nx    = idx;
    case (state)
      IDLE: begin
        if (occ_nx != '0) state_nx = STREAM;
      end
      STREAM: begin
        if (xfer) begin
          if (last_beat) begin
            idx_nx = '0;
            if (occ_nx == '0) state_nx = IDLE;
          end else begin
            idx_nx = idx + IW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output decode; data is forced to zero while nothing is being presented.
  always_comb begin
    o_valid    = (state == STREAM);
    o_last     = last_beat;
    o_idx      = idx;
    o_data     = o_valid ? rd_word : '0;
    o_cap_rdy  = (occ != OW'(SLOTS));
    o_overflow = ovf;
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain: directed scenarios plus random traffic against a queue model.
module tb_pe_result_drain;

  localparam int W     = 16;
  localparam int N     = 4;
  localparam int SLOTS = 2;
  localparam int IW    = 2;

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic           i_done;
  logic [N*W-1:0] i_C;
  logic           o_cap_rdy;
  logic [W-1:0]   o_data;
  logic [IW-1:0]  o_idx;
  logic           o_last;
  logic           o_valid;
  logic           i_ready;
  logic           o_overflow;
  logic           i_clr_ovf;

  int checks   = 0;
  int failures = 0;

  // Model: queue of buffered snapshots (head is being streamed), beat position, overflow.
  logic [N*W-1:0] snaps[$];
  int             pos;
  logic           m_ovf;

  pe_result_drain #(.W(W), .N(N), .SLOTS(SLOTS)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_done     (i_done),
    .i_C        (i_C),
    .o_cap_rdy  (o_cap_rdy),
    .o_data     (o_data),
    .o_idx      (o_idx),
    .o_last     (o_last),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_overflow (o_overflow),
    .i_clr_ovf  (i_clr_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] row(input int base);
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(base + k);
    return r;
  endfunction

  // One clock cycle: called just after a rising edge, returns just after the next one.
  task automatic cycle(input logic done, input logic [N*W-1:0] c, input logic rdy,
                       input logic clr);
    logic           m_valid, m_last, xfer, accept;
    logic [N*W-1:0] head;
    logic [W-1:0]   word;
    i_done    = done;
    i_C       = c;
    i_ready   = rdy;
    i_clr_ovf = clr;
    @(negedge i_clk);
    m_valid = (snaps.size() > 0);
    m_last  = m_valid && (pos == N - 1);
    chk("valid", 64'(o_valid), 64'(m_valid));
    chk("idx", 64'(o_idx), 64'(pos));
    chk("last", 64'(o_last), 64'(m_last));
    chk("cap_rdy", 64'(o_cap_rdy), 64'(snaps.size() < SLOTS));
    chk("overflow", 64'(o_overflow), 64'(m_ovf));
    if (m_valid) begin
      head = snaps[0];
      word = head[pos*W +: W];
      chk("data", 64'(o_data), 64'(word));
    end
    xfer   = m_valid && rdy;
    accept = done && ((snaps.size() < SLOTS) || (xfer && m_last));
    @(posedge i_clk);
    #1;
    if (xfer) begin
      if (m_last) begin
        void'(snaps.pop_front());
        pos = 0;
      end else begin
        pos++;
      end
    end
    if (accept) snaps.push_back(c);
    if (done && !accept) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  initial begin
    pos       = 0;
    m_ovf     = 1'b0;
    i_rst_n   = 1'b0;
    i_done    = 1'b0;
    i_C       = '0;
    i_ready   = 1'b0;
    i_clr_ovf = 1'b0;
    #12;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_idx", 64'(o_idx), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    chk("rst_cap_rdy", 64'(o_cap_rdy), 64'd1);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Single snapshot, consumer always ready.
    cycle(1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b0);

    // Backpressure for three cycles while word 1 is presented.
    cycle(1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, '0, 1'b1, 1'b0);

    // Back-to-back snapshots stream without a bubble.
    cycle(1'b1, row(1), 1'b1, 1'b0);
    cycle(1'b1, row(5), 1'b1, 1'b0);
    repeat (9) cycle(1'b0, '0, 1'b1, 1'b0);

    // Three captures while stalled: third dropped, overflow set then cleared.
    cycle(1'b1, row(16'h10), 1'b0, 1'b0);
    cycle(1'b1, row(16'h20), 1'b0, 1'b0);
    cycle(1'b1, row(16'h30), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b0);

    // Full buffer, capture coincident with the final beat of the oldest slot.
    cycle(1'b1, row(16'h40), 1'b0, 1'b0);
    cycle(1'b1, row(16'h50), 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, row(16'h60), 1'b1, 1'b0);
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 2) == 0, (N*W)'({$urandom(), $urandom()}),
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    repeat (12) cycle(1'b0, '0, 1'b1, 1'b1);

    // Reset asserted while word 2 is presented.
    cycle(1'b1, row(16'h70), 1'b1, 1'b0);
    cycle(1'b1, row(16'h80), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_idx", 64'(o_idx), 64'd0);
    chk("midrst_cap_rdy", 64'(o_cap_rdy), 64'd1);
    snaps.delete();
    pos   = 0;
    m_ovf = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, row(16'h90), 1'b1, 1'b0);
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
